// File: rtl/read_stream_engine.sv
// read_stream_engine: streams tagged cache-line read commands for one array job,
// keeps up to MAX_OUTSTANDING commands in flight, re-issues retried lines ahead of
// new ones and counts completed elements for the job-done logic.
module read_stream_engine #(
  parameter int unsigned ADDR_W          = 64,
  parameter int unsigned ARRAY_SIZE_BITS = 32,
  parameter int unsigned ELEM_BYTES      = 4,
  parameter int unsigned LINE_BYTES      = 128,
  parameter int unsigned MAX_OUTSTANDING = 8,
  parameter int unsigned TAG_W           = $clog2(MAX_OUTSTANDING),
  parameter logic [7:0]  READ_ID         = 8'd0
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       enable_in,
  input  logic                       start_in,
  input  logic [ADDR_W-1:0]          base_addr_in,
  input  logic [ARRAY_SIZE_BITS-1:0] num_elements_in,
  input  logic [7:0]                 stride_lines_in,
  input  logic                       cmd_buf_full_in,
  output logic                       cmd_valid_out,
  output logic [ADDR_W-1:0]          cmd_addr_out,
  output logic [7:0]                 cmd_size_out,
  output logic [TAG_W-1:0]           cmd_tag_out,
  output logic [7:0]                 cmd_id_out,
  input  logic                       rsp_valid_in,
  input  logic [TAG_W-1:0]           rsp_tag_in,
  input  logic [1:0]                 rsp_status_in,
  output logic [ARRAY_SIZE_BITS-1:0] job_counter_done,
  output logic                       busy_out,
  output logic                       done_out,
  output logic                       error_out
);

  localparam int unsigned EPL     = LINE_BYTES / ELEM_BYTES;   // elements per full line
  localparam int unsigned EW      = $clog2(EPL) + 1;
  localparam int unsigned LB_W    = $clog2(LINE_BYTES) + 1;
  localparam int unsigned LINE_SH = $clog2(LINE_BYTES);
  localparam int unsigned CW      = TAG_W + 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE, S_ERROR} state_t;

  state_t                       state;
  logic [ADDR_W-1:0]            next_addr;
  logic [ARRAY_SIZE_BITS-1:0]   elems_left;
  logic [7:0]                   stride_r;

  logic [MAX_OUTSTANDING-1:0]   slot_busy;
  logic [MAX_OUTSTANDING-1:0]   slot_pend;   // busy slot waiting in the retry FIFO
  logic [ADDR_W-1:0]            slot_addr  [MAX_OUTSTANDING];
  logic [7:0]                   slot_size  [MAX_OUTSTANDING];
  logic [EW-1:0]                slot_elems [MAX_OUTSTANDING];

  logic [TAG_W-1:0]             fifo_mem [MAX_OUTSTANDING];
  logic [TAG_W-1:0]             fifo_rd, fifo_wr;
  logic [CW-1:0]                fifo_cnt;

  logic                         free_ok;
  logic [TAG_W-1:0]             free_idx;
  logic                         rsp_hit, rsp_done, rsp_retry, rsp_fail;
  logic                         issue_ok, retry_go, new_go, err_exit, full_line;
  logic [TAG_W-1:0]             retry_tag;
  logic [LB_W-1:0]              tail_bytes;
  logic [EW-1:0]                new_elems;
  logic [7:0]                   new_size;
  logic [ADDR_W-1:0]            line_step;

  // Smallest power of two that holds b bytes
  function automatic logic [7:0] round_pow2(input logic [LB_W-1:0] b);
    logic [LB_W-1:0] p;
    p = LB_W'(1);
    for (int i = 0; i < int'(LB_W); i++) begin
      if (p < b) p = p << 1;
    end
    return 8'(p);
  endfunction

  assign cmd_id_out = READ_ID;

  // Lowest-index free slot
  always_comb begin
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = int'(MAX_OUTSTANDING) - 1; i >= 0; i--) begin
      if (!slot_busy[TAG_W'(i)]) begin
        free_ok  = 1'b1;
        free_idx = TAG_W'(i);
      end
    end
  end

  assign rsp_hit   = rsp_valid_in && slot_busy[rsp_tag_in];
  assign rsp_done  = rsp_hit && (rsp_status_in == 2'b00);
  assign rsp_retry = rsp_hit && (rsp_status_in == 2'b01);
  assign rsp_fail  = rsp_hit && rsp_status_in[1];

  assign full_line  = elems_left >= ARRAY_SIZE_BITS'(EPL);
  assign tail_bytes = LB_W'(elems_left) * LB_W'(ELEM_BYTES);
  assign new_elems  = full_line ? EW'(EPL) : EW'(elems_left);
  assign new_size   = full_line ? 8'(LINE_BYTES) : round_pow2(tail_bytes);
  assign line_step  = ADDR_W'(stride_r) << LINE_SH;
  assign retry_tag  = fifo_mem[fifo_rd];

  // Retries keep their own slot, so only new lines need a free one
  assign issue_ok = ((state == S_ISSUE) || (state == S_DRAIN)) && enable_in &&
                    !cmd_buf_full_in && !rsp_fail;
  assign retry_go = issue_ok && (fifo_cnt != '0);
  assign new_go   = issue_ok && (state == S_ISSUE) && (fifo_cnt == '0) &&
                    (elems_left != '0) && free_ok;
  // Slots parked in the retry FIFO are abandoned once the job has failed
  assign err_exit = (state == S_ERROR) && ((slot_busy & ~slot_pend) == '0);

  // Slot occupancy and retry FIFO pointers
  always_ff @(posedge clock) begin
    if (rst || err_exit) begin
      slot_busy <= '0;
      slot_pend <= '0;
      fifo_rd   <= '0;
      fifo_wr   <= '0;
      fifo_cnt  <= '0;
    end else begin
      if (new_go) slot_busy[free_idx] <= 1'b1;
      if (rsp_done || rsp_fail) slot_busy[rsp_tag_in] <= 1'b0;
      if (rsp_retry) begin
        slot_pend[rsp_tag_in] <= 1'b1;
        fifo_wr               <= fifo_wr + TAG_W'(1);
      end
      if (retry_go) begin
        slot_pend[retry_tag] <= 1'b0;
        fifo_rd              <= fifo_rd + TAG_W'(1);
      end
      fifo_cnt <= fifo_cnt + CW'(rsp_retry) - CW'(retry_go);
    end
  end

  // Slot payloads and FIFO storage need no reset
  always_ff @(posedge clock) begin
    if (new_go) begin
      slot_addr[free_idx]  <= next_addr;
      slot_size[free_idx]  <= new_size;
      slot_elems[free_idx] <= new_elems;
    end
    if (rsp_retry) fifo_mem[fifo_wr] <= rsp_tag_in;
  end

  // Job FSM with registered command and status outputs
  always_ff @(posedge clock) begin
    if (rst) begin
      state            <= S_IDLE;
      next_addr        <= '0;
      elems_left       <= '0;
      stride_r         <= 8'd0;
      cmd_valid_out    <= 1'b0;
      cmd_addr_out     <= '0;
      cmd_size_out     <= 8'd0;
      cmd_tag_out      <= '0;
      job_counter_done <= '0;
      busy_out         <= 1'b0;
      done_out         <= 1'b0;
      error_out        <= 1'b0;
    end else begin
      cmd_valid_out <= 1'b0;
      done_out      <= 1'b0;
      if (retry_go) begin
        cmd_valid_out <= 1'b1;
        cmd_addr_out  <= slot_addr[retry_tag];
        cmd_size_out  <= slot_size[retry_tag];
        cmd_tag_out   <= retry_tag;
      end else if (new_go) begin
        cmd_valid_out <= 1'b1;
        cmd_addr_out  <= next_addr;
        cmd_size_out  <= new_size;
        cmd_tag_out   <= free_idx;
        next_addr     <= next_addr + line_step;
        elems_left    <= elems_left - ARRAY_SIZE_BITS'(new_elems);
      end
      if (rsp_done) job_counter_done <= job_counter_done + ARRAY_SIZE_BITS'(slot_elems[rsp_tag_in]);
      if (rsp_fail) error_out <= 1'b1;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            job_counter_done <= '0;
            error_out        <= 1'b0;
            next_addr        <= base_addr_in;
            elems_left       <= num_elements_in;
            stride_r         <= (stride_lines_in == 8'd0) ? 8'd1 : stride_lines_in;
            busy_out         <= 1'b1;
            state            <= (num_elements_in == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (rsp_fail) state <= S_ERROR;
          else if ((elems_left == '0) && (fifo_cnt == '0)) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (rsp_fail) state <= S_ERROR;
          else if (slot_busy == '0) state <= S_DONE;
        end
        S_DONE: begin
          state    <= S_IDLE;
          done_out <= 1'b1;
          busy_out <= 1'b0;
        end
        S_ERROR: begin
          if (err_exit) begin
            state    <= S_IDLE;
            done_out <= 1'b1;
            busy_out <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Responses must target an outstanding slot
  always_ff @(posedge clock) begin
    if (!rst && rsp_valid_in) begin
      a_rsp_slot_busy: assert (slot_busy[rsp_tag_in]);
    end
  end

endmodule

// File: tb/tb_read_stream_engine.sv
// Directed bench for read_stream_engine with default parameters.
module tb_read_stream_engine;

  logic        clock = 1'b0;
  logic        rst;
  logic        enable_in;
  logic        start_in;
  logic [63:0] base_addr_in;
  logic [31:0] num_elements_in;
  logic [7:0]  stride_lines_in;
  logic        cmd_buf_full_in;
  logic        cmd_valid_out;
  logic [63:0] cmd_addr_out;
  logic [7:0]  cmd_size_out;
  logic [2:0]  cmd_tag_out;
  logic [7:0]  cmd_id_out;
  logic        rsp_valid_in;
  logic [2:0]  rsp_tag_in;
  logic [1:0]  rsp_status_in;
  logic [31:0] job_counter_done;
  logic        busy_out;
  logic        done_out;
  logic        error_out;

  int checks = 0;
  int errors = 0;

  logic [63:0] mon_addr[$];
  logic [7:0]  mon_size[$];
  logic [2:0]  mon_tag[$];
  int          done_seen = 0;

  localparam logic [1:0] ST_DONE  = 2'b00;
  localparam logic [1:0] ST_RETRY = 2'b01;
  localparam logic [1:0] ST_FAIL  = 2'b10;

  read_stream_engine dut (
    .clock(clock), .rst(rst), .enable_in(enable_in), .start_in(start_in),
    .base_addr_in(base_addr_in), .num_elements_in(num_elements_in),
    .stride_lines_in(stride_lines_in), .cmd_buf_full_in(cmd_buf_full_in),
    .cmd_valid_out(cmd_valid_out), .cmd_addr_out(cmd_addr_out), .cmd_size_out(cmd_size_out),
    .cmd_tag_out(cmd_tag_out), .cmd_id_out(cmd_id_out), .rsp_valid_in(rsp_valid_in),
    .rsp_tag_in(rsp_tag_in), .rsp_status_in(rsp_status_in),
    .job_counter_done(job_counter_done), .busy_out(busy_out), .done_out(done_out),
    .error_out(error_out)
  );

  always #5 clock = ~clock;

  // Record every presented command and completion pulse
  always @(negedge clock) begin
    if (cmd_valid_out === 1'b1) begin
      mon_addr.push_back(cmd_addr_out);
      mon_size.push_back(cmd_size_out);
      mon_tag.push_back(cmd_tag_out);
    end
    if (done_out === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; enable_in = 1'b0; start_in = 1'b0; cmd_buf_full_in = 1'b0;
    base_addr_in = '0; num_elements_in = '0; stride_lines_in = 8'd1;
    rsp_valid_in = 1'b0; rsp_tag_in = '0; rsp_status_in = '0;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic start_job(input logic [63:0] base, input logic [31:0] n, input logic [7:0] stride);
    base_addr_in = base; num_elements_in = n; stride_lines_in = stride;
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
  endtask

  task automatic send_rsp(input logic [2:0] tag, input logic [1:0] st);
    rsp_valid_in = 1'b1; rsp_tag_in = tag; rsp_status_in = st;
    tick();
    rsp_valid_in = 1'b0;
  endtask

  task automatic wait_cmds(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (mon_addr.size() >= target) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (done_seen >= target) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL reset_cmd_valid got %b exp 0", cmd_valid_out); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_out); end
    checks++; if (done_out !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_out); end
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL reset_error got %b exp 0", error_out); end
    checks++; if (job_counter_done !== 32'd0) begin errors++; $display("FAIL reset_counter got %0d exp 0", job_counter_done); end
    checks++; if (cmd_id_out !== 8'h00) begin errors++; $display("FAIL reset_cmd_id got %h exp 00", cmd_id_out); end
  endtask

  task automatic test_basic();
    int b, d;
    bit ok;
    enable_in = 1'b1;
    b = mon_addr.size(); d = done_seen;
    start_job(64'h1000, 32'd64, 8'd1);
    wait_cmds(b + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d cmds exp 2", mon_addr.size() - b); end
    if (ok) begin
      checks++; if (mon_addr[b] !== 64'h1000) begin errors++; $display("FAIL basic_addr0 got %h exp 1000", mon_addr[b]); end
      checks++; if (mon_addr[b+1] !== 64'h1080) begin errors++; $display("FAIL basic_addr1 got %h exp 1080", mon_addr[b+1]); end
      checks++; if (mon_size[b] !== 8'd128 || mon_size[b+1] !== 8'd128) begin errors++; $display("FAIL basic_size got %0d/%0d exp 128/128", mon_size[b], mon_size[b+1]); end
      checks++; if (mon_tag[b] !== 3'd0 || mon_tag[b+1] !== 3'd1) begin errors++; $display("FAIL basic_tags got %0d/%0d exp 0/1", mon_tag[b], mon_tag[b+1]); end
    end
    repeat (5) tick();
    checks++; if (mon_addr.size() != b + 2) begin errors++; $display("FAIL basic_count got %0d exp 2", mon_addr.size() - b); end
    checks++; if (busy_out !== 1'b1) begin errors++; $display("FAIL basic_busy got %b exp 1", busy_out); end
    send_rsp(3'd0, ST_DONE);
    send_rsp(3'd1, ST_DONE);
    wait_done(d + 1, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_done_timeout got %0d exp 1", done_seen - d); end
    repeat (3) tick();
    checks++; if (done_seen != d + 1) begin errors++; $display("FAIL basic_done_pulses got %0d exp 1", done_seen - d); end
    checks++; if (job_counter_done !== 32'd64) begin errors++; $display("FAIL basic_counter got %0d exp 64", job_counter_done); end
    checks++; if (busy_out !== 1'b0) begin errors++; $display("FAIL basic_idle got %b exp 0", busy_out); end
  endtask

  task automatic test_tail();
    logic [63:0] t_base [5];
    logic [31:0] t_n    [5];
    logic [7:0]  t_str  [5];
    logic [63:0] t_a1   [5];
    logic [7:0]  t_s1   [5];
    int b, d;
    bit ok;
    t_base = '{64'h1000, 64'h1000, 64'h2000, 64'h2000, 64'hFFFF_FFFF_FFFF_FF80};
    t_n    = '{32'd40, 32'd35, 32'd64, 32'd64, 32'd64};
    t_str  = '{8'd1, 8'd1, 8'd0, 8'd3, 8'd1};
    t_a1   = '{64'h1080, 64'h1080, 64'h2080, 64'h2180, 64'h0};
    t_s1   = '{8'd32, 8'd16, 8'd128, 8'd128, 8'd128};
    enable_in = 1'b1;
    for (int k = 0; k < 5; k++) begin
      b = mon_addr.size(); d = done_seen;
      start_job(t_base[k], t_n[k], t_str[k]);
      wait_cmds(b + 2, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tail%0d_timeout got %0d cmds exp 2", k, mon_addr.size() - b); end
      if (ok) begin
        checks++; if (mon_addr[b] !== t_base[k] || mon_size[b] !== 8'd128) begin errors++; $display("FAIL tail%0d_line0 got %h/%0d exp %h/128", k, mon_addr[b], mon_size[b], t_base[k]); end
        checks++; if (mon_addr[b+1] !== t_a1[k]) begin errors++; $display("FAIL tail%0d_addr1 got %h exp %h", k, mon_addr[b+1], t_a1[k]); end
        checks++; if (mon_size[b+1] !== t_s1[k]) begin errors++; $display("FAIL tail%0d_size1 got %0d exp %0d", k, mon_size[b+1], t_s1[k]); end
      end
      send_rsp(3'd0, ST_DONE);
      send_rsp(3'd1, ST_DONE);
      wait_done(d + 1, 20, ok);
      checks++; if (!ok) begin errors++; $display("FAIL tail%0d_done_timeout got %0d exp 1", k, done_seen - d); end
      checks++; if (job_counter_done !== t_n[k]) begin errors++; $display("FAIL tail%0d_counter got %0d exp %0d", k, job_counter_done, t_n[k]); end
      tick();
    end
  endtask

  task automatic test_outstanding();
    int b;
    bit ok;
    apply_reset();
    enable_in = 1'b1;
    b = mon_addr.size();
    start_job(64'h1000, 32'd1024, 8'd1);
    wait_cmds(b + 8, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL out_timeout got %0d cmds exp 8", mon_addr.size() - b); end
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (mon_tag[b+i] !== 3'(i) || mon_addr[b+i] !== 64'h1000 + 64'(i) * 64'h80) begin
          errors++; $display("FAIL out_cmd%0d got tag %0d addr %h exp tag %0d addr %h", i, mon_tag[b+i], mon_addr[b+i], i, 64'h1000 + 64'(i) * 64'h80);
        end
      end
    end
    repeat (5) tick();
    checks++; if (mon_addr.size() != b + 8) begin errors++; $display("FAIL out_stall got %0d cmds exp 8", mon_addr.size() - b); end
    send_rsp(3'd3, ST_DONE);
    checks++; if (cmd_valid_out !== 1'b0) begin errors++; $display("FAIL out_early got %b exp 0", cmd_valid_out); end
    checks++; if (job_counter_done !== 32'd32) begin errors++; $display("FAIL out_counter got %0d exp 32", job_counter_done); end
    tick();
    checks++; if (cmd_valid_out !== 1'b1 || cmd_tag_out !== 3'd3 || cmd_addr_out !== 64'h1400) begin
      errors++; $display("FAIL out_reuse got v%b tag %0d addr %h exp v1 tag 3 addr 1400", cmd_valid_out, cmd_tag_out, cmd_addr_out);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++; if (busy_out !== 1'b0 || cmd_valid_out !== 1'b0) begin errors++; $display("FAIL out_rst got busy %b valid %b exp 0 0", busy_out, cmd_valid_out); end
    rst = 1'b0;
  endtask

  task automatic test_retry();
    int b;
    bit ok;
    apply_reset();
    enable_in = 1'b1;
    b = mon_addr.size();
    start_job(64'h1000, 32'd1024, 8'd1);
    wait_cmds(b + 8, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_fill got %0d cmds exp 8", mon_addr.size() - b); end
    enable_in = 1'b0;
    send_rsp(3'd2, ST_RETRY);
    checks++; if (job_counter_done !== 32'd0) begin errors++; $display("FAIL retry_counter got %0d exp 0", job_counter_done); end
    send_rsp(3'd5, ST_DONE);
    checks++; if (job_counter_done !== 32'd32) begin errors++; $display("FAIL retry_done5 got %0d exp 32", job_counter_done); end
    b = mon_addr.size();
    enable_in = 1'b1;
    wait_cmds(b + 2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL retry_timeout got %0d cmds exp 2", mon_addr.size() - b); end
    if (ok) begin
      checks++; if (mon_addr[b] !== 64'h1100 || mon_tag[b] !== 3'd2) begin errors++; $display("FAIL retry_first got %h tag %0d exp 1100 tag 2", mon_addr[b], mon_tag[b]); end
      checks++; if (mon_addr[b+1] !== 64'h1400 || mon_tag[b+1] !== 3'd5) begin errors++; $display("FAIL retry_second got %h tag %0d exp 1400 tag 5", mon_addr[b+1], mon_tag[b+1]); end
    end
    send_rsp(3'd2, ST_DONE);
    checks++; if (job_counter_done !== 32'd64) begin errors++; $display("FAIL retry_done2 got %0d exp 64", job_counter_done); end
  endtask

  task automatic test_fail();
    int b, d;
    bit ok;
    apply_reset();
    enable_in = 1'b1;
    b = mon_addr.size();
    start_job(64'h1000, 32'd1024, 8'd1);
    repeat (4) tick();
    enable_in = 1'b0;
    repeat (3) tick();
    checks++; if (mon_addr.size() != b + 4) begin errors++; $display("FAIL fail_inflight got %0d exp 4", mon_addr.size() - b); end
    enable_in = 1'b1;
    send_rsp(3'd1, ST_FAIL);
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL fail_flag got %b exp 1", error_out); end
    repeat (10) tick();
    checks++; if (mon_addr.size() != b + 4) begin errors++; $display("FAIL fail_no_issue got %0d exp 4", mon_addr.size() - b); end
    d = done_seen;
    send_rsp(3'd0, ST_DONE);
    send_rsp(3'd2, ST_DONE);
    tick();
    checks++; if (done_seen != d || busy_out !== 1'b1) begin errors++; $display("FAIL fail_early_done got %0d busy %b exp 0 busy 1", done_seen - d, busy_out); end
    send_rsp(3'd3, ST_DONE);
    wait_done(d + 1, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL fail_done_timeout got %0d exp 1", done_seen - d); end
    checks++; if (error_out !== 1'b1) begin errors++; $display("FAIL fail_sticky got %b exp 1", error_out); end
    tick();
    start_job(64'h1000, 32'd0, 8'd1);
    checks++; if (error_out !== 1'b0) begin errors++; $display("FAIL fail_clear got %b exp 0", error_out); end
    repeat (3) tick();
  endtask

  task automatic test_misc();
    int b, d;
    bit ok;
    // backpressure hold
    apply_reset();
    enable_in = 1'b1;
    cmd_buf_full_in = 1'b1;
    b = mon_addr.size();
    start_job(64'h1000, 32'd1024, 8'd1);
    repeat (10) tick();
    checks++; if (mon_addr.size() != b || cmd_valid_out !== 1'b0) begin errors++; $display("FAIL bp_hold got %0d cmds exp 0", mon_addr.size() - b); end
    cmd_buf_full_in = 1'b0;
    wait_cmds(b + 8, 30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_release got %0d cmds exp 8", mon_addr.size() - b); end
    if (ok) begin
      checks++; if (mon_addr[b] !== 64'h1000 || mon_tag[b] !== 3'd0) begin errors++; $display("FAIL bp_first got %h tag %0d exp 1000 tag 0", mon_addr[b], mon_tag[b]); end
    end
    // start while busy
    d = done_seen;
    start_job(64'h9000, 32'd0, 8'd1);
    repeat (4) tick();
    checks++; if (busy_out !== 1'b1 || done_seen != d) begin errors++; $display("FAIL busy_start got busy %b done %0d exp 1 0", busy_out, done_seen - d); end
    send_rsp(3'd0, ST_DONE);
    wait_cmds(b + 9, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_start_next got %0d cmds exp 9", mon_addr.size() - b); end
    if (ok) begin
      checks++; if (mon_addr[b+8] !== 64'h1400) begin errors++; $display("FAIL busy_start_addr got %h exp 1400", mon_addr[b+8]); end
    end
    // empty job
    apply_reset();
    b = mon_addr.size();
    start_job(64'h1000, 32'd0, 8'd1);
    checks++; if (done_out !== 1'b0 || busy_out !== 1'b1) begin errors++; $display("FAIL zero_c1 got done %b busy %b exp 0 1", done_out, busy_out); end
    tick();
    checks++; if (done_out !== 1'b1) begin errors++; $display("FAIL zero_c2 got done %b exp 1", done_out); end
    tick();
    checks++; if (done_out !== 1'b0 || busy_out !== 1'b0) begin errors++; $display("FAIL zero_c3 got done %b busy %b exp 0 0", done_out, busy_out); end
    checks++; if (mon_addr.size() != b) begin errors++; $display("FAIL zero_cmds got %0d exp 0", mon_addr.size() - b); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tail();
    test_outstanding();
    test_retry();
    test_fail();
    test_misc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
